// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round sequencer.
// State encoding, statemt owner codes and the legal round counts.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARK,
    S_SUB,
    S_MIX,
    S_SUB_F,
    S_DONE
  } state_t;

  localparam logic [1:0] MEM_SEL_ARK  = 2'd0;
  localparam logic [1:0] MEM_SEL_SUB  = 2'd1;
  localparam logic [1:0] MEM_SEL_MIX  = 2'd2;
  localparam logic [1:0] MEM_SEL_NONE = 2'd3;

  localparam logic [3:0] NR_10 = 4'd10;
  localparam logic [3:0] NR_12 = 4'd12;
  localparam logic [3:0] NR_14 = 4'd14;

  function automatic logic is_legal_nr(input logic [3:0] n);
    return (n == NR_10) || (n == NR_12) || (n == NR_14);
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    logic [1:0] r;
    r = MEM_SEL_NONE;
    unique case (s)
      S_ARK:   r = MEM_SEL_ARK;
      S_SUB:   r = MEM_SEL_SUB;
      S_SUB_F: r = MEM_SEL_SUB;
      S_MIX:   r = MEM_SEL_MIX;
      default: r = MEM_SEL_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_kernel_launch.sv
// Start/done handshake for one HLS kernel.
// Idle kernels raise done with start low, so done counts only with start.
module aes_kernel_launch (
  input  logic clk,
  input  logic rst_n,
  input  logic launch,
  input  logic done,
  output logic start,
  output logic acc
);

  assign acc = done & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start <= 1'b0;
    end else if (launch) begin
      start <= 1'b1;
    end else if (acc) begin
      start <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES encrypt round controller: sequences ARK/SUB/MIX kernels
// and hands the statemt RAM to exactly one kernel at a time.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NR_MAX = 14,
  parameter int N_W    = 6
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic           ap_start,
  output logic           ap_done,
  output logic           ap_idle,
  output logic           ap_ready,
  input  logic [3:0]     nr,
  output logic           err,
  output logic           ark_start,
  output logic           sub_start,
  output logic           mix_start,
  input  logic           ark_done,
  input  logic           sub_done,
  input  logic           mix_done,
  output logic [N_W-1:0] ark_n,
  output logic [1:0]     mem_sel,
  output logic [3:0]     round
);

  state_t     state, state_d;
  logic [3:0] round_d;
  logic [3:0] nr_q, nr_d;
  logic       err_d;
  logic       ark_go, sub_go, mix_go;
  logic       ark_acc, sub_acc, mix_acc;
  logic       legal;

  aes_kernel_launch u_ark (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .launch (ark_go),
    .done   (ark_done),
    .start  (ark_start),
    .acc    (ark_acc)
  );

  aes_kernel_launch u_sub (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .launch (sub_go),
    .done   (sub_done),
    .start  (sub_start),
    .acc    (sub_acc)
  );

  aes_kernel_launch u_mix (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .launch (mix_go),
    .done   (mix_done),
    .start  (mix_start),
    .acc    (mix_acc)
  );

  assign legal = is_legal_nr(nr) && (int'(nr) <= NR_MAX);

  always_comb begin
    state_d = state;
    round_d = round;
    nr_d    = nr_q;
    err_d   = err;
    ark_go  = 1'b0;
    sub_go  = 1'b0;
    mix_go  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ap_start) begin
          nr_d    = nr;
          round_d = 4'd0;
          if (legal) begin
            err_d   = 1'b0;
            ark_go  = 1'b1;
            state_d = S_ARK;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ARK: begin
        if (ark_acc) begin
          if (round == nr_q) begin
            state_d = S_DONE;
          end else begin
            sub_go  = 1'b1;
            state_d = (round == 4'(nr_q - 4'd1)) ? S_SUB_F : S_SUB;
          end
        end
      end
      S_SUB: begin
        if (sub_acc) begin
          round_d = 4'(round + 4'd1);
          mix_go  = 1'b1;
          state_d = S_MIX;
        end
      end
      S_MIX: begin
        if (mix_acc) begin
          ark_go  = 1'b1;
          state_d = S_ARK;
        end
      end
      S_SUB_F: begin
        if (sub_acc) begin
          round_d = 4'(round + 4'd1);
          ark_go  = 1'b1;
          state_d = S_ARK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Owner code and done are registered from the next state so they
  // change on the same edge as the kernel starts.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state   <= S_IDLE;
      round   <= 4'd0;
      nr_q    <= 4'd0;
      err     <= 1'b0;
      ap_done <= 1'b0;
      ark_n   <= '0;
      mem_sel <= MEM_SEL_NONE;
    end else begin
      state   <= state_d;
      round   <= round_d;
      nr_q    <= nr_d;
      err     <= err_d;
      ap_done <= (state_d == S_DONE);
      mem_sel <= sel_of(state_d);
      if (ark_go) begin
        ark_n <= N_W'(round_d);
      end
    end
  end

  assign ap_idle  = (state == S_IDLE);
  assign ap_ready = ap_done;

endmodule
